// File: rtl/square_freq_detect_pkg.sv
// rtl/square_freq_detect_pkg.sv - shared synth constants and crossing-detector types
package square_freq_detect_pkg;

    localparam int SYNTH_WIDTH          = 24;
    localparam int SYNTH_PHASE_ACC_BITS = 32;
    localparam int FREQ_DET_PERIOD_BITS = 16;

    localparam logic signed [SYNTH_WIDTH-1:0]   FREQ_DET_HYST       = 24'sd4096;
    localparam logic [FREQ_DET_PERIOD_BITS-1:0] FREQ_DET_MIN_PERIOD = 16'd4;
    localparam logic [FREQ_DET_PERIOD_BITS-1:0] FREQ_DET_MAX_PERIOD = 16'd65535;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        HIGH     = 2'd2
    } xing_state_t;

endpackage

// File: rtl/recip_divider.sv
// rtl/recip_divider.sv - restoring divider computing floor(2^N / divisor)
module recip_divider
    import square_freq_detect_pkg::*;
#(
    parameter int N  = SYNTH_PHASE_ACC_BITS,
    parameter int PW = FREQ_DET_PERIOD_BITS
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [PW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [N-1:0]  o_quotient
);

    localparam int             IW      = $clog2(N + 2);
    localparam logic [IW-1:0]  IDX_TOP = IW'(N);

    logic [IW-1:0] r_idx;
    logic [PW-1:0] r_div;
    logic [PW-1:0] r_rem;
    logic [N-1:0]  r_quo;
    logic          r_busy;
    logic          r_done;

    logic          w_bit;
    logic [PW:0]   w_rem_sh;
    logic          w_ge;
    logic [PW-1:0] w_rem_nxt;

    // The dividend 2^N has a single set bit, at the first iteration only.
    assign w_bit     = (r_idx == IDX_TOP);
    assign w_rem_sh  = {r_rem, w_bit};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? PW'(w_rem_sh - {1'b0, r_div}) : PW'(w_rem_sh);

    // One quotient bit per cycle over N+1 iterations; the leading bit is always
    // zero for divisors >= 2 and simply shifts out of the N-bit register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_div  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_div  <= i_divisor;
                r_rem  <= '0;
                r_quo  <= '0;
                r_idx  <= IDX_TOP;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_quo <= {r_quo[N-2:0], w_ge};
                r_idx <= r_idx - 1'b1;
                if (r_idx == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/square_freq_detect.sv
// rtl/square_freq_detect.sv - period measurement to phase increment recovery
module square_freq_detect
    import square_freq_detect_pkg::*;
#(
    parameter logic signed [SYNTH_WIDTH-1:0]   HYST       = FREQ_DET_HYST,
    parameter logic [FREQ_DET_PERIOD_BITS-1:0] MIN_PERIOD = FREQ_DET_MIN_PERIOD,
    parameter logic [FREQ_DET_PERIOD_BITS-1:0] MAX_PERIOD = FREQ_DET_MAX_PERIOD
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic signed [SYNTH_WIDTH-1:0]   sample_in,
    input  logic                            sample_valid_in,
    output logic [SYNTH_PHASE_ACC_BITS-1:0] phase_incr_out,
    output logic                            incr_valid_out,
    output logic                            locked_out
);

    localparam int PW = FREQ_DET_PERIOD_BITS;
    localparam int N  = SYNTH_PHASE_ACC_BITS;
    localparam logic signed [SYNTH_WIDTH-1:0] NEG_HYST = -HYST;

    xing_state_t   r_state;
    xing_state_t   w_state_nxt;
    logic [PW-1:0] r_count;
    logic          r_first_seen;
    logic [N-1:0]  r_phase;
    logic          r_incr_valid;
    logic          r_locked;

    logic          w_rise;
    logic          w_timeout;
    logic          w_crossing;
    logic          w_launch;
    logic          w_div_busy;
    logic          w_div_done;
    logic [N-1:0]  w_div_quo;

    // Counter reaching the limit means the signal is gone; this beats a crossing.
    assign w_timeout  = sample_valid_in & r_first_seen & (r_count == MAX_PERIOD);
    assign w_crossing = w_rise & ~w_timeout;
    assign w_launch   = w_crossing & r_first_seen & ~w_div_busy
                      & (r_count >= MIN_PERIOD) & (r_count < MAX_PERIOD);

    // Crossing state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= WAIT_LOW;
        else        r_state <= w_state_nxt;
    end

    // Hysteretic crossing detection: only ARMED -> HIGH counts as a rising crossing.
    always_comb begin
        w_state_nxt = r_state;
        w_rise      = 1'b0;
        if (sample_valid_in) begin
            case (r_state)
                WAIT_LOW: if (sample_in <= NEG_HYST) w_state_nxt = ARMED;
                ARMED: begin
                    if (sample_in >= HYST) begin
                        w_state_nxt = HIGH;
                        w_rise      = 1'b1;
                    end
                end
                HIGH:     if (sample_in <= NEG_HYST) w_state_nxt = ARMED;
                default:  w_state_nxt = WAIT_LOW;
            endcase
        end
        if (w_timeout) w_state_nxt = WAIT_LOW;
    end

    // Period counter: reloads to 1 on every crossing, counts samples once armed.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_count      <= '0;
            r_first_seen <= 1'b0;
        end else if (w_timeout) begin
            r_count      <= '0;
            r_first_seen <= 1'b0;
        end else if (w_crossing) begin
            r_count      <= PW'(1);
            r_first_seen <= 1'b1;
        end else if (sample_valid_in && r_first_seen) begin
            r_count      <= r_count + PW'(1);
        end
    end

    recip_divider #(
        .N  (N),
        .PW (PW)
    ) u_div (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_start    (w_launch),
        .i_abort    (w_timeout),
        .i_divisor  (r_count),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_div_quo)
    );

    // Output registers: a timeout reports zero/unlocked, a finished division reports lock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_phase      <= '0;
            r_incr_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_incr_valid <= 1'b0;
            if (w_timeout) begin
                r_phase      <= '0;
                r_incr_valid <= 1'b1;
                r_locked     <= 1'b0;
            end else if (w_div_done) begin
                r_phase      <= w_div_quo;
                r_incr_valid <= 1'b1;
                r_locked     <= 1'b1;
            end
        end
    end

    assign phase_incr_out = r_phase;
    assign incr_valid_out = r_incr_valid;
    assign locked_out     = r_locked;

endmodule

// File: tb/tb_square_freq_detect.sv
// tb/tb_square_freq_detect.sv - self-checking bench for square_freq_detect
module tb_square_freq_detect;

    localparam int NB   = 32;
    localparam int MAXP = 65535;
    localparam int MINP = 4;
    localparam int HYS  = 4096;
    localparam logic signed [23:0] SP = 24'h7FFFFF;
    localparam logic signed [23:0] SN = 24'h800000;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic signed [23:0]  sample_in = '0;
    logic                sample_valid_in = 1'b0;
    logic [NB-1:0]       phase_incr_out;
    logic                incr_valid_out;
    logic                locked_out;

    square_freq_detect dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .phase_incr_out  (phase_incr_out),
        .incr_valid_out  (incr_valid_out),
        .locked_out      (locked_out)
    );

    initial forever #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: expectations derived from sample indices and edge times.
    typedef struct {
        int          at;
        logic [31:0] val;
        logic        lck;
    } pend_t;

    pend_t       q[$];
    int          cyc = 0;
    int          sidx = 0;
    int          last_cross = 0;
    int          last_launch = -1000;
    int          side = 0;
    bit          first_seen = 0;
    bit          exp_valid = 0;
    logic [31:0] exp_phase = '0;
    bit          exp_locked = 0;
    int          s_m;
    int          per;
    bit          tmo;
    bit          rise;
    longint      two_n = 64'd1 << NB;

    initial forever begin
        @(posedge clk_in);
        cyc++;
        if (rst_in) begin
            q.delete();
            sidx = 0; last_cross = 0; last_launch = -1000; side = 0;
            first_seen = 0; exp_valid = 0; exp_phase = '0; exp_locked = 0;
        end else begin
            if (sample_valid_in) begin
                sidx++;
                s_m  = sample_in;
                tmo  = first_seen && (sidx - last_cross == MAXP);
                rise = (side == -1) && (s_m >= HYS);
                if (tmo) begin
                    while (q.size() > 0 && q[$].at >= cyc) void'(q.pop_back());
                    q.push_back('{cyc, 32'd0, 1'b0});
                    first_seen  = 0;
                    side        = 0;
                    last_launch = -1000;
                end else begin
                    if (s_m <= -HYS) side = -1;
                    else if (rise)   side = 1;
                    if (rise) begin
                        if (first_seen) begin
                            per = sidx - last_cross;
                            if (per >= MINP && per < MAXP && (cyc - last_launch) > NB + 1) begin
                                q.push_back('{cyc + NB + 2, 32'(two_n / per), 1'b1});
                                last_launch = cyc;
                            end
                        end
                        first_seen = 1;
                        last_cross = sidx;
                    end
                end
            end
            exp_valid = 0;
            if (q.size() > 0 && q[0].at == cyc) begin
                exp_valid  = 1;
                exp_phase  = q[0].val;
                exp_locked = q[0].lck;
                void'(q.pop_front());
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk_in);
        chk("incr_valid", {63'd0, incr_valid_out}, {63'd0, rst_in ? 1'b0 : exp_valid});
        chk("phase_incr", {32'd0, phase_incr_out}, {32'd0, rst_in ? 32'd0 : exp_phase});
        chk("locked",     {63'd0, locked_out},     {63'd0, rst_in ? 1'b0 : exp_locked});
    end

    // Pulse monitor for the literal scenario checks.
    int          n_pulses = 0;
    int          last_pulse_cyc = 0;
    logic [31:0] last_pulse_val = '0;
    logic        last_pulse_lck = 1'b0;
    initial forever begin
        @(negedge clk_in);
        if (incr_valid_out === 1'b1) begin
            n_pulses++;
            last_pulse_cyc = cyc;
            last_pulse_val = phase_incr_out;
            last_pulse_lck = locked_out;
        end
    end

    task automatic tick(input logic v, input logic signed [23:0] s);
        sample_valid_in = v;
        sample_in       = s;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (3) tick(1'b0, '0);
        rst_in = 1'b0;
    endtask

    task automatic square_blocks(input int nblk, input bit start_low, input int half);
        for (int b = 0; b < nblk; b++)
            for (int i = 0; i < half; i++)
                tick(1'b1, ((b % 2 == 0) == start_low) ? SN : SP);
    endtask

    int xc;
    int np0;
    int half;
    int gap;
    int sel;
    logic signed [23:0] amp;

    initial begin
        // Reset state
        repeat (3) tick(1'b0, '0);
        chk("reset_phase",  {32'd0, phase_incr_out}, 64'd0);
        chk("reset_valid",  {63'd0, incr_valid_out}, 64'd0);
        chk("reset_locked", {63'd0, locked_out},     64'd0);
        rst_in = 1'b0;

        // 1) 50/50 full-scale square, valid every 4th clock; also pulse latency
        np0 = n_pulses;
        xc  = 0;
        for (int i = 0; i < 250; i++) begin
            tick(1'b1, ((i / 50) % 2 == 0) ? SP : SN);
            if (i == 200) xc = cyc;
            repeat (3) tick(1'b0, ((i / 50) % 2 == 0) ? SP : SN);
        end
        chk("t1_pulses",  64'(n_pulses - np0), 64'd1);
        chk("t1_phase",   {32'd0, last_pulse_val}, 64'd42949672);
        chk("t1_locked",  {63'd0, last_pulse_lck}, 64'd1);
        chk("t6_latency", 64'(last_pulse_cyc - xc), 64'(NB + 2));

        // 2) period-3 square after a P=52 lock: no further updates
        for (int g = 0; g < 40; g++) begin
            tick(1'b1, SN); tick(1'b1, SN); tick(1'b1, SP);
        end
        chk("t2_p52_phase", {32'd0, phase_incr_out}, 64'd82595524);
        np0 = n_pulses;
        for (int g = 0; g < 40; g++) begin
            tick(1'b1, SN); tick(1'b1, SN); tick(1'b1, SP);
        end
        chk("t2_pulses", 64'(n_pulses - np0), 64'd0);
        chk("t2_phase",  {32'd0, phase_incr_out}, 64'd82595524);
        chk("t2_locked", {63'd0, locked_out}, 64'd1);

        // 3) sub-hysteresis oscillation never crosses
        do_reset();
        np0 = n_pulses;
        for (int i = 0; i < 200; i++) tick(1'b1, (i % 2 == 0) ? 24'sd2000 : -24'sd2000);
        chk("t3_pulses", 64'(n_pulses - np0), 64'd0);
        chk("t3_locked", {63'd0, locked_out}, 64'd0);

        // 4) lock at P=100, then silence until timeout, then relock
        do_reset();
        square_blocks(4, 1'b1, 50);
        chk("t4_lock_phase", {32'd0, phase_incr_out}, 64'd42949672);
        np0 = n_pulses;
        for (int i = 0; i < 65535; i++) tick(1'b1, '0);
        chk("t4_to_pulses", 64'(n_pulses - np0), 64'd1);
        chk("t4_to_phase",  {32'd0, last_pulse_val}, 64'd0);
        chk("t4_to_locked", {63'd0, locked_out}, 64'd0);
        square_blocks(4, 1'b1, 50);
        chk("t4_relock_phase",  {32'd0, phase_incr_out}, 64'd42949672);
        chk("t4_relock_locked", {63'd0, locked_out}, 64'd1);

        // 5) asynchronous reset during a division
        for (int i = 0; i < 50; i++) tick(1'b1, SN);
        tick(1'b1, SP);
        for (int i = 0; i < 10; i++) tick(1'b1, SP);
        #3 rst_in = 1'b1;
        #1;
        chk("t5_async_phase",  {32'd0, phase_incr_out}, 64'd0);
        chk("t5_async_locked", {63'd0, locked_out}, 64'd0);
        @(posedge clk_in); #1;
        repeat (2) tick(1'b0, SP);
        rst_in = 1'b0;
        np0 = n_pulses;
        for (int i = 0; i < 60; i++) tick(1'b1, SP);
        chk("t5_no_pulse", 64'(n_pulses - np0), 64'd0);
        square_blocks(4, 1'b1, 50);
        for (int i = 0; i < 40; i++) tick(1'b1, SP);
        chk("t5_relock_phase", {32'd0, phase_incr_out}, 64'd42949672);

        // Randomized: varying half-periods, amplitudes near the hysteresis edge, gaps
        for (int sgm = 0; sgm < 45; sgm++) begin
            half = $urandom_range(1, 30);
            sel  = $urandom_range(0, 9);
            case (sel)
                0:       amp = 24'sd2000;
                1:       amp = 24'sd4095;
                2:       amp = 24'sd4096;
                default: amp = SP;
            endcase
            for (int ph = 0; ph < 2; ph++)
                for (int i = 0; i < half; i++) begin
                    tick(1'b1, (ph == 0) ? amp : -amp);
                    gap = $urandom_range(0, 2);
                    repeat (gap) tick(1'b0, 24'($urandom));
                end
        end
        repeat (50) tick(1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
